// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - rx_state_t     : receiver FSM state encoding
//   - DEFAULT_CLKDIV : clk cycles per bit for 50 MHz / 115200 baud
//   - FIFO_DEPTH     : receive storage depth when UART_RX_FIFO_EN is defined
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        WAITHI = 3'd4
    } rx_state_t;

    localparam int unsigned DEFAULT_CLKDIV = 434;
    localparam int unsigned FIFO_DEPTH     = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Byte storage for the UART receiver. DEPTH = 1 behaves as a single holding
// register, DEPTH = 4 as a small circular FIFO.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   push, push_data  : write request and byte
//   pop              : read request (ignored while empty)
//   head             : oldest stored byte, 8'h00 while empty
//   full, empty      : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle; the
// pop frees the head slot first, so the new byte lands where it was.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (wr_ptr_q == PTR_W'(i))) begin
                    mem_q[i] <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with sticky framing/overrun flags.
// Configuration macro: UART_RX_FIFO_EN -- when defined, received bytes go to
// a 4-entry FIFO; otherwise to a single holding register.
// Parameter: CLKDIV -- clk cycles per bit (4..65535).
// Ports:
//   clk      : clock
//   reset    : asynchronous active-high reset
//   rx       : serial input, asynchronous, idle high
//   re       : read strobe, pops the head byte when valid=1
//   err_clr  : clears ferr and ovr (a same-cycle new error wins)
//   rdata    : head byte, 8'h00 when valid=0
//   valid    : at least one byte stored
//   ferr     : sticky framing error
//   ovr      : sticky overrun
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKDIV = DEFAULT_CLKDIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       re,
    input  logic       err_clr,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       ferr,
    output logic       ovr
);
`ifdef UART_RX_FIFO_EN
    localparam int STORE_DEPTH = int'(FIFO_DEPTH);
`else
    localparam int STORE_DEPTH = 1;
`endif

    // Half a bit to reach the middle of the start bit, then whole bits.
    localparam logic [15:0] HALF_RELOAD = 16'(CLKDIV / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(CLKDIV - 1);

    logic       rx_meta_q, rx_meta_d;
    logic       rx_sync_q, rx_sync_d;
    rx_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    logic       push;
    logic       frame_err;
    logic       st_full;
    logic       st_empty;
    logic       overrun;

    uart_rx_fifo #(
        .DEPTH (STORE_DEPTH)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_q),
        .pop       (re),
        .head      (rdata),
        .full      (st_full),
        .empty     (st_empty)
    );

    assign valid = !st_empty;
    assign ferr  = ferr_q;
    assign ovr   = ovr_q;

    // A push into full storage is lost unless the same cycle pops the head.
    assign overrun = push && st_full && !(re && valid);

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        state_d   = DATA;
                        cnt_d     = FULL_RELOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB first
                    cnt_d   = FULL_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAITHI: begin
                // A held-low line (break) must not start another frame.
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ferr_d = frame_err ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
        ovr_d  = overrun   ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with CLKDIV=16. A frame-level model keeps the
// stored bytes in a queue and the flags as bits; each sent frame schedules
// its outcome (byte or framing error) at the cycle the receiver decides it.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLKDIV = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // Two synchronizer flops, one IDLE detect cycle, half a bit of start,
    // then eight data bits and the stop bit.
    localparam int LAT = 3 + CLKDIV / 2 + 9 * CLKDIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       re;
    logic       err_clr;
    logic [7:0] rdata;
    logic       valid;
    logic       ferr;
    logic       ovr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mq[$];
    int         ev_edge[$];
    bit         ev_err[$];
    logic [7:0] ev_data[$];
    bit         m_ferr = 1'b0;
    bit         m_ovr  = 1'b0;

    uart_rx #(.CLKDIV(CLKDIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .re      (re),
        .err_clr (err_clr),
        .rdata   (rdata),
        .valid   (valid),
        .ferr    (ferr),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model update on every rising edge, comparison 1 time unit later.
    initial begin
        bit ev_f;
        bit ev_o;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                ev_edge.delete();
                ev_err.delete();
                ev_data.delete();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                ev_f = 1'b0;
                ev_o = 1'b0;
                if (re && mq.size() > 0) void'(mq.pop_front());
                if (ev_edge.size() > 0 && ev_edge[0] == cyc) begin
                    if (ev_err[0]) ev_f = 1'b1;
                    else if (mq.size() < DEPTH) mq.push_back(ev_data[0]);
                    else ev_o = 1'b1;
                    void'(ev_edge.pop_front());
                    void'(ev_err.pop_front());
                    void'(ev_data.pop_front());
                end
                m_ferr = ev_f ? 1'b1 : (err_clr ? 1'b0 : m_ferr);
                m_ovr  = ev_o ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
            end
            #1;
            chk1("model_valid", valid, mq.size() > 0);
            chk8("model_rdata", rdata, (mq.size() > 0) ? mq[0] : 8'h00);
            chk1("model_ferr", ferr, m_ferr);
            chk1("model_ovr", ovr, m_ovr);
        end
    end

    // Called at a falling edge; drives the 10-bit frame and leaves rx at the
    // stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit sched);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        if (sched) begin
            ev_edge.push_back(cyc + LAT);
            ev_err.push_back(!stop_bit);
            ev_data.push_back(b);
        end
        $display("tx byte 0x%02h stop=%0b start_cycle=%0d", b, stop_bit, cyc);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CLKDIV) @(negedge clk);
        end
    endtask

    task automatic pulse_re();
        $display("rd strobe valid=%0b rdata=0x%02h cycle=%0d", valid, rdata, cyc);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        $display("err_clr ferr=%0b ovr=%0b cycle=%0d", ferr, ovr, cyc);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [7:0] last;
        logic [7:0] exp_head;
        logic [9:0] fr;

        reset = 1'b1; rx = 1'b1; re = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_valid", valid, 1'b0);
        chk8("rst_rdata", rdata, 8'h00);
        chk1("rst_ferr", ferr, 1'b0);
        chk1("rst_ovr", ovr, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Basic byte.
        send_frame(8'hA5, 1'b1, 1'b1);
        chk1("a5_valid", valid, 1'b1);
        chk8("a5_rdata", rdata, 8'hA5);
        chk1("a5_ferr", ferr, 1'b0);
        chk1("a5_ovr", ovr, 1'b0);
        pulse_re();
        chk1("a5_pop_valid", valid, 1'b0);
        chk8("a5_pop_rdata", rdata, 8'h00);

        // Read while empty is ignored.
        pulse_re();
        chk1("empty_re_valid", valid, 1'b0);

        // Short low glitch.
        $display("glitch 5 cycles cycle=%0d", cyc);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk8("glitch_idle", 8'(dut.state_q), 8'(IDLE));
        chk1("glitch_valid", valid, 1'b0);

        // Framing error followed by a 40-bit break.
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (40 * CLKDIV) @(negedge clk);
        chk1("break_ferr", ferr, 1'b1);
        chk1("break_valid", valid, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        pulse_clr();
        chk1("break_ferr_clr", ferr, 1'b0);

        // Overrun: DEPTH+1 bytes, err_clr colliding with the overrun event.
        for (int k = 1; k <= DEPTH; k++) send_frame(8'(k), 1'b1, 1'b1);
        fork
            send_frame(8'(DEPTH + 1), 1'b1, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
        join
        chk1("ovr_set", ovr, 1'b1);
        chk1("ovr_valid", valid, 1'b1);
        chk8("ovr_head", rdata, 8'h01);
        for (int k = 1; k <= DEPTH; k++) begin
            chk8("ovr_order", rdata, 8'(k));
            pulse_re();
        end
        chk1("ovr_drained", valid, 1'b0);
        pulse_clr();
        chk1("ovr_clr", ovr, 1'b0);

        // Full storage, read on the exact push cycle.
        for (int k = 1; k <= DEPTH; k++) send_frame(8'(16 + k), 1'b1, 1'b1);
        fork
            send_frame(8'hEE, 1'b1, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                re = 1'b1;
                @(negedge clk);
                re = 1'b0;
            end
        join
        chk1("same_cycle_ovr", ovr, 1'b0);
        exp_head = (DEPTH == 1) ? 8'hEE : 8'h12;
        chk8("same_cycle_head", rdata, exp_head);
        last = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            last = rdata;
            pulse_re();
        end
        chk8("same_cycle_tail", last, 8'hEE);

        // Reset in the middle of data bit 4 of 0xFF, with a byte stored.
        send_frame(8'h77, 1'b1, 1'b1);
        chk1("pre_rst_valid", valid, 1'b1);
        fr = {1'b1, 8'hFF, 1'b0};
        $display("tx byte 0xFF aborted by reset start_cycle=%0d", cyc);
        for (int i = 0; i < 5; i++) begin
            rx = fr[i];
            repeat (CLKDIV) @(negedge clk);
        end
        rx = fr[5];
        repeat (CLKDIV / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk1("midrst_valid", valid, 1'b0);
        chk8("midrst_rdata", rdata, 8'h00);
        chk1("midrst_ferr", ferr, 1'b0);
        chk1("midrst_ovr", ovr, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk1("post_rst_valid", valid, 1'b1);
        chk8("post_rst_rdata", rdata, 8'h5A);
        pulse_re();
        chk1("post_rst_pop", valid, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
